// File: rtl/scroll_step_ctrl.sv
// Scroll position generator: synchronises and debounces the scroll button,
// adds an optional auto-scroll timer, and steps a 4-bit position per event.
module scroll_step_ctrl #(
  parameter int unsigned DB_CYCLES   = 500000,
  parameter int unsigned AUTO_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       dir,
  output logic [3:0] count_en,
  output logic       step_pulse
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES);
  localparam int unsigned AT_W = $clog2(AUTO_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_CYCLES - 1);

  logic            s1;
  logic            s2;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;
  logic [AT_W-1:0] at_cnt;
  logic            press;
  logic            tick;
  logic            step;

  // Event decode from registered state only.
  always_comb begin
    press = stable & ~stable_d;
    tick  = auto_en & (at_cnt == AT_LAST);
    step  = press | tick;
  end

  // Two-flop synchroniser; btn is read nowhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive matching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      stable_d <= stable;
      if (s2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Auto-scroll period counter; a press restarts the period.
  always_ff @(posedge clk) begin
    if (reset) begin
      at_cnt <= '0;
    end else if (!auto_en || press || (at_cnt == AT_LAST)) begin
      at_cnt <= '0;
    end else begin
      at_cnt <= at_cnt + AT_W'(1);
    end
  end

  // Position register and its change strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_en   <= 4'd0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step;
      if (step) begin
        count_en <= dir ? (count_en - 4'd1) : (count_en + 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_scroll_step_ctrl.sv
// Scoreboard bench for scroll_step_ctrl: directed scenarios plus random
// button/auto/dir/reset traffic checked against an event-level model.
module tb_scroll_step_ctrl;

  localparam int DB = 4;
  localparam int AT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       auto_en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] count_en;
  logic       step_pulse;

  scroll_step_ctrl #(.DB_CYCLES(DB), .AUTO_CYCLES(AT)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .auto_en   (auto_en),
    .dir       (dir),
    .count_en  (count_en),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_on = 1'b0;
  logic [3:0] exp_q[$];
  int step_log[$];

  // Reference model state: button delay line, run length of disagreeing
  // samples, anchor edge of the auto period, and the expected position.
  bit       b1, b2, m_stable, rise_pend;
  int       run;
  int       z;
  bit [3:0] m_count;

  always @(posedge clk) begin : model
    bit s2_now;
    bit press_now;
    bit tick_now;
    cyc = cyc + 1;
    if (reset) begin
      b1 = 0; b2 = 0; m_stable = 0; run = 0; rise_pend = 0;
      m_count = 4'd0; z = cyc;
    end else begin
      s2_now = b2; b2 = b1; b1 = btn;
      press_now = rise_pend;
      rise_pend = 0;
      if (s2_now != m_stable) begin
        run = run + 1;
        if (run == DB) begin
          m_stable = s2_now;
          run = 0;
          rise_pend = m_stable;
        end
      end else begin
        run = 0;
      end
      tick_now = auto_en && (((cyc - 1 - z) % AT) == AT - 1);
      if (!auto_en || press_now) z = cyc;
      if (press_now || tick_now) begin
        m_count = dir ? (m_count - 4'd1) : (m_count + 4'd1);
        exp_q.push_back(m_count);
      end
    end
  end

  // Monitor: a queued step must appear as step_pulse with the queued value;
  // otherwise the position must hold and no strobe may appear.
  always @(negedge clk) begin
    if (mon_on) begin
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        total++;
        if (step_pulse !== 1'b1 || count_en !== e) begin
          bad++;
          $display("FAIL step at edge %0d: count_en=%0d step_pulse=%b, required count_en=%0d step_pulse=1",
                   cyc, count_en, step_pulse, e);
        end
      end else begin
        total++;
        if (step_pulse !== 1'b0 || count_en !== m_count) begin
          bad++;
          $display("FAIL hold at edge %0d: count_en=%0d step_pulse=%b, required count_en=%0d step_pulse=0",
                   cyc, count_en, step_pulse, m_count);
        end
      end
      if (step_pulse === 1'b1) step_log.push_back(cyc);
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  function automatic int off_at(input int idx, input int base);
    return (step_log.size() > idx) ? step_log[idx] - base : -1;
  endfunction

  int e0;
  int exp_e[7] = '{9, 19, 24, 34, 44, 54, 64};

  initial begin
    // Reset and idle
    @(negedge clk);
    chk("reset count_en", int'(count_en), 0);
    chk("reset step_pulse", int'(step_pulse), 0);
    cyc_n(1);
    reset = 1'b0;
    mon_on = 1'b1;
    cyc_n(50);
    chk("idle count_en", int'(count_en), 0);
    chk("idle steps", step_log.size(), 0);

    // Clean press held 30 cycles
    step_log.delete();
    e0 = cyc + 1;
    btn = 1'b1;
    cyc_n(30);
    btn = 1'b0;
    cyc_n(20);
    chk("clean press steps", step_log.size(), 1);
    chk("clean press edge", off_at(0, e0), 6);
    chk("clean press count", int'(count_en), 1);

    // Bounce then hold
    step_log.delete();
    btn = 1'b1; cyc_n(2);
    btn = 1'b0; cyc_n(2);
    btn = 1'b1; cyc_n(2);
    btn = 1'b0; cyc_n(2);
    e0 = cyc + 1;
    btn = 1'b1;
    cyc_n(20);
    btn = 1'b0;
    cyc_n(20);
    chk("bounce steps", step_log.size(), 1);
    chk("bounce edge", off_at(0, e0), 6);
    chk("bounce count", int'(count_en), 2);

    // Backward wrap, then 16 forward auto ticks
    reset = 1'b1; cyc_n(1); reset = 1'b0;
    chk("reset mid count_en", int'(count_en), 0);
    step_log.delete();
    dir = 1'b1;
    btn = 1'b1; cyc_n(10);
    btn = 1'b0; cyc_n(12);
    chk("back wrap count", int'(count_en), 15);
    dir = 1'b0;
    auto_en = 1'b1;
    cyc_n(160);
    auto_en = 1'b0;
    cyc_n(2);
    chk("auto wrap count", int'(count_en), 15);
    chk("auto wrap steps", step_log.size(), 17);

    // Auto period, press restart, press coinciding with tick
    reset = 1'b1; cyc_n(1); reset = 1'b0;
    step_log.delete();
    e0 = cyc + 1;
    auto_en = 1'b1;
    cyc_n(18);
    btn = 1'b1; cyc_n(10);
    btn = 1'b0; cyc_n(20);
    btn = 1'b1; cyc_n(8);
    btn = 1'b0; cyc_n(13);
    auto_en = 1'b0;
    cyc_n(2);
    chk("auto steps", step_log.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("auto edge %0d", i), off_at(i, e0), exp_e[i]);
    chk("auto count", int'(count_en), 7);

    // Reset during a partial debounce with the button held
    cyc_n(5);
    step_log.delete();
    e0 = cyc + 1;
    btn = 1'b1;
    cyc_n(4);
    reset = 1'b1; cyc_n(1); reset = 1'b0;
    chk("reset held count_en", int'(count_en), 0);
    chk("reset held step_pulse", int'(step_pulse), 0);
    cyc_n(15);
    btn = 1'b0;
    cyc_n(15);
    chk("reset held steps", step_log.size(), 1);
    chk("reset held edge", off_at(0, e0), 11);
    chk("reset held count", int'(count_en), 1);

    // Random traffic
    for (int s = 0; s < 150; s++) begin
      int len;
      len = int'($urandom_range(1, 12));
      btn = 1'($urandom_range(0, 1));
      auto_en = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1; cyc_n(1); reset = 1'b0;
      end
      cyc_n(len);
    end
    btn = 1'b0;
    auto_en = 1'b0;
    cyc_n(20);
    chk("final queue empty", exp_q.size(), 0);
    chk("final count", int'(count_en), int'(m_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
